// File: rtl/putc_uart_tx.sv
// putc character sink: valid/ready byte FIFO feeding an 8N1 LSB-first UART transmitter.
// tx is registered from the next-state values, so the start bit goes out on the edge that pops.
module putc_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  putc_valid,
  input  logic [7:0]            putc_data,
  output logic                  putc_ready,
  output logic                  tx,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   fifo_count
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0]   BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [2:0]              bit_idx_q, bit_idx_d;
  logic [7:0]              shift_q, shift_d;
  logic                    tx_q, tx_d;
  logic                    push, pop, fifo_empty, baud_done;

  assign fifo_empty = (count_q == '0);
  assign putc_ready = (count_q != FULL_COUNT);
  assign push       = putc_valid && putc_ready;
  assign baud_done  = (baud_q == BAUD_LAST);

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign fifo_count = count_q;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
      STOP: begin
        // Chain straight into the next start bit when more bytes are waiting.
        if (baud_done) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      shift_d = mem[rd_ptr_q];
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr_q] <= putc_data;
    end
  end

endmodule

// File: tb/tb_putc_uart_tx.sv
// Bench for putc_uart_tx: directed and random pushes, checked against an ideal 8N1 line model
// and a bench-side UART receiver that decodes the tx pin.
module tb_putc_uart_tx;
  localparam int C     = 4;
  localparam int DL    = 2;
  localparam int FRAME = 10 * C;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          putc_valid = 1'b0;
  logic [7:0]    putc_data = 8'h00;
  logic          putc_ready;
  logic          tx;
  logic          busy;
  logic [DL:0]   fifo_count;

  putc_uart_tx #(.CLKS_PER_BIT(C), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .putc_valid(putc_valid), .putc_data(putc_data),
    .putc_ready(putc_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int rst_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) rst_cnt <= rst_cnt + 1;
  end

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] line_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Ideal line level t cycles after the first start bit of the frames queued in line_q.
  function automatic logic ref_line(input int t);
    int f = t / FRAME;
    int o = t % FRAME;
    logic [7:0] b;
    if (f >= line_q.size()) return 1'b1;
    if (o < C) return 1'b0;
    if (o >= 9 * C) return 1'b1;
    b = line_q[f];
    return b[o / C - 1];
  endfunction

  task automatic check_line(input string tag, input int n, output int lows);
    lows = 0;
    for (int t = 0; t < n; t++) begin
      chk({tag, "_tx"}, 32'(tx), 32'(ref_line(t)));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (tx === 1'b0) lows++;
      step();
    end
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    putc_valid = 1'b1;
    putc_data  = b;
    while (putc_ready !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    chk("push_ready", 32'(putc_ready), 32'd1);
    step();
    putc_valid = 1'b0;
    exp_q.push_back(b);
    $display("push 0x%02h accepted at cycle %0d", b, cyc);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      step();
      n++;
    end
    chk("idle", 32'(busy), 32'd0);
    repeat (4) step();
  endtask

  task automatic compare_rx(input string tag);
    chk({tag, "_rxcount"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk({tag, "_rxbyte"}, 32'(rx_q[i]), 32'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  // Reference receiver: samples mid-bit, drops any frame that a reset interrupted.
  initial begin : rx_model
    logic [7:0] d;
    int r0;
    logic start_ok;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        r0 = rst_cnt;
        d  = 8'h00;
        repeat (C / 2) @(negedge clk);
        start_ok = (tx === 1'b0);
        for (int k = 0; k < 8; k++) begin
          repeat (C) @(negedge clk);
          d[k] = tx;
        end
        repeat (C) @(negedge clk);
        if (rst_cnt == r0) begin
          chk("rx_start", 32'(start_ok), 32'd1);
          chk("rx_stop", 32'(tx), 32'd1);
          rx_q.push_back(d);
          $display("rx byte 0x%02h decoded at cycle %0d", d, cyc);
        end
      end
    end
  end

  initial begin : main
    int s;
    int lows;
    int n;
    logic [7:0] b;

    repeat (3) step();
    rst = 1'b0;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(putc_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    repeat (2) step();

    // Single byte 'A'
    push(8'h41);
    chk("t1_count", 32'(fifo_count), 32'd1);
    chk("t1_tx_pre", 32'(tx), 32'd1);
    step();
    line_q = '{8'h41};
    check_line("t1", FRAME, lows);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_tx_end", 32'(tx), 32'd1);
    compare_rx("t1");

    // Two bytes on consecutive cycles
    putc_valid = 1'b1;
    putc_data  = 8'h48;
    step();
    putc_data  = 8'h69;
    chk("t2_count1", 32'(fifo_count), 32'd1);
    step();
    putc_valid = 1'b0;
    chk("t2_count_pushpop", 32'(fifo_count), 32'd1);
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h69);
    line_q = '{8'h48, 8'h69};
    check_line("t2", 2 * FRAME, lows);
    chk("t2_busy_end", 32'(busy), 32'd0);
    compare_rx("t2");
    repeat (3) step();

    // Hold valid across a full FIFO; blocked push at the pop cycle
    push(8'h30);
    s = cyc;
    for (int i = 1; i < 5; i++) push(8'(8'h30 + i));
    chk("t3_full_count", 32'(fifo_count), 32'd4);
    chk("t3_full_ready", 32'(putc_ready), 32'd0);
    putc_valid = 1'b1;
    putc_data  = 8'h35;
    n = 0;
    while (putc_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("t4_ready_rise_cyc", 32'(cyc), 32'(s + 1 + FRAME));
    chk("t4_count_drop", 32'(fifo_count), 32'd3);
    step();
    putc_valid = 1'b0;
    exp_q.push_back(8'h35);
    chk("t4_count_refill", 32'(fifo_count), 32'd4);
    push(8'h36);
    wait_idle(10 * FRAME);
    compare_rx("t3");

    // Reset during data bit 3 of 0x55 with two bytes queued
    push(8'h55);
    s = cyc + 1;
    push(8'h11);
    push(8'h22);
    chk("t5_queued", 32'(fifo_count), 32'd2);
    n = 0;
    while (cyc < s + 17 && n < 100) begin
      step();
      n++;
    end
    chk("t5_bit3", 32'(tx), 32'd0);
    rst = 1'b1;
    putc_valid = 1'b1;
    putc_data  = 8'h77;
    step();
    rst = 1'b0;
    putc_valid = 1'b0;
    exp_q.delete();
    chk("t5_tx", 32'(tx), 32'd1);
    chk("t5_count", 32'(fifo_count), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ready", 32'(putc_ready), 32'd1);
    lows = 0;
    repeat (60) begin
      step();
      if (tx !== 1'b1) lows++;
    end
    chk("t5_quiet", 32'(lows), 32'd0);
    chk("t5_count_after", 32'(fifo_count), 32'd0);
    chk("t5_rx_none", 32'(rx_q.size()), 32'd0);
    push(8'h5A);
    wait_idle(2 * FRAME);
    compare_rx("t5");

    // 0xFF then 0x00
    putc_valid = 1'b1;
    putc_data  = 8'hFF;
    step();
    putc_data  = 8'h00;
    step();
    putc_valid = 1'b0;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    line_q = '{8'hFF, 8'h00};
    check_line("t6", 2 * FRAME, lows);
    chk("t6_lows", 32'(lows), 32'(C + 9 * C));
    chk("t6_busy_end", 32'(busy), 32'd0);
    compare_rx("t6");

    // Random bytes with random gaps
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 3)) step();
      push(b);
    end
    wait_idle(30 * FRAME);
    compare_rx("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/putc_uart_tx.md
# putc_uart_tx

Character sink for the CPU's `putc` instruction. It accepts bytes from the core through a valid/ready handshake and buffers them in a small FIFO. It then serializes each byte onto a UART line as 8N1, LSB first. It sits between the CPU core and the board's TX pin, and takes the place of the simulation-only `$display` path for hardware builds.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥ 2.
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 bytes (16).

Ports:
- `clk`, input, 1 bit: single system clock. All logic is on the rising edge.
- `rst`, input, 1 bit: synchronous reset, active-high.
- `putc_valid`, input, 1 bit: the core presents a byte.
- `putc_data`, input, 8 bits: byte to send. The core drives the low 8 bits of the `rd` register.
- `putc_ready`, output, 1 bit: FIFO can accept a byte. Equals `!full`.
- `tx`, output, 1 bit: UART serial line. Idles high.
- `busy`, output, 1 bit: a frame is in flight or the FIFO is non-empty.
- `fifo_count`, output, DEPTH_LOG2+1 bits: number of bytes currently buffered.

## Operation
- Push: on a clock edge with `putc_valid && putc_ready`, `putc_data` is written at `wr_ptr`, and `wr_ptr` increments (wraps modulo depth). The core must hold `putc_valid` and `putc_data` stable until `putc_ready` is high.
- Push while full: `putc_ready` is low, so nothing is written and `fifo_count` is unchanged. There is no overwrite and no pass-through, even when a pop happens in the same cycle.
- Pop: occurs when the FSM leaves IDLE or STOP for START with the FIFO non-empty. The byte at `rd_ptr` is loaded into the 8-bit shift register, and `rd_ptr` increments (wraps).
- Simultaneous push and pop: `fifo_count` is unchanged, and both pointers advance.
- FSM states are IDLE, START, DATA and STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with `bit_idx`=0.
  - DATA: `tx`=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Baud counter: counts from 0 to CLKS_PER_BIT-1, resets to 0 on every state or bit change, and is sized $clog2(CLKS_PER_BIT).
- `busy` = (state != IDLE) || (fifo_count != 0).
- Reset values: `tx`=1, `putc_ready`=1, `busy`=0, `fifo_count`=0. FSM goes to IDLE, and the pointers, baud counter and `bit_idx` go to 0.
- Reset mid-frame: the frame is aborted. `tx` is 1 on the cycle after the reset edge, and all buffered bytes are discarded. If `putc_valid` is asserted during reset, nothing is accepted.

## Timing
- `tx` is a registered output, with no combinational path from inputs.
- Push to `fifo_count` update: 1 cycle.
- Latency from an idle, empty block:
  - Byte accepted at edge N.
  - The FSM sees non-empty at edge N+1 and pops.
  - `tx` falls after edge N+1.
  - First-byte latency is 2 edges from the accepting edge to the start bit.
- Frame length is exactly 10×CLKS_PER_BIT cycles:
  - start bit: [0, C)
  - data bit k: [(k+1)C, (k+2)C)
  - stop bit: [9C, 10C)
- Back-to-back frames: the next start bit begins at cycle 10C of the previous frame, with no gap.
- `putc_ready` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the next pop.
- Throughput: one byte per 10×CLKS_PER_BIT cycles. The core must stall on `!putc_ready`.

## Test plan
All directed tests use CLKS_PER_BIT=4 and DEPTH_LOG2=2.
- After reset, push 0x41 ('A').
  - `tx` goes low 2 edges later.
  - The sampled bit sequence is 0, 1,0,0,0,0,0,1,0, 1, with each level lasting exactly 4 cycles.
  - `busy` drops at cycle 40 of the frame.
- Push 0x48, 0x69 on consecutive cycles.
  - Two frames are sent back-to-back: 80 cycles, no idle-high gap beyond the stop bit.
  - Both decode correctly.
- Hold `putc_valid` with bytes 0x30 to 0x36.
  - `putc_ready` deasserts once `fifo_count`=4 (the first byte is already popped, so 5 are accepted).
  - Every byte 0x30 to 0x36 appears on `tx` exactly once and in order, with no loss or duplication.
- Push while full, at the exact cycle a pop occurs: the push is not accepted (ready was 0), and `fifo_count` drops 4→3.
- Assert `rst` for 1 cycle during data bit 3 of 0x55 while 2 bytes are queued.
  - `tx`=1 on the next cycle, and `fifo_count`=0.
  - No further frames are sent.
  - A new push of 0x5A is then sent cleanly.
- Push 0xFF and then 0x00: the line stays high across stop-bit boundaries, the frame of 0x00 holds `tx` low for 36 cycles, and both are decoded by the bench's reference UART receiver.
